// File: rtl/truncation_sram_pkg.sv
// Shared constants, FSM state type and request record for the truncation SRAM sequencer.
package truncation_sram_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NUM_WL = 1 << ADDR_W;

  typedef enum logic [1:0] {
    StIdle,
    StPrech,
    StAccess,
    StRecov
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] trunc;
    logic              byte_mode;
    logic              tail;
  } req_t;

  // Byte mode returns only the low byte of the macro's read data.
  function automatic logic [DATA_W-1:0] mask_rdata(input logic [DATA_W-1:0] data,
                                                   input logic              byte_mode);
    logic [DATA_W-1:0] res;
    res = data;
    if (byte_mode) begin
      res[DATA_W-1:8] = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/truncation_sram_wl_dec.sv
// Registered one-hot wordline decoder; all wordlines low when not enabled.
module truncation_sram_wl_dec
  import truncation_sram_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NUM_WL-1:0] wl_o
);

  logic [NUM_WL-1:0] wl_d, wl_q;

  // Decode the index into a single asserted wordline
  always_comb begin
    wl_d = '0;
    if (en_i) begin
      wl_d[addr_i] = 1'b1;
    end
  end

  // Wordlines come straight from flops so the macro never sees decode glitches
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wl_q <= '0;
    end else begin
      wl_q <= wl_d;
    end
  end

  assign wl_o = wl_q;

endmodule

// File: rtl/truncation_sram_ctrl.sv
// Access sequencer for the truncation SRAM macro: precharge, wordline/enable window, recovery.
// Every pin toward the macro is a flop output, computed one cycle ahead from the next state.
module truncation_sram_ctrl
  import truncation_sram_pkg::*;
#(
  parameter int unsigned PRE_CYCLES    = 2,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_trunc,
  input  logic              req_byte_mode,
  input  logic              req_tail,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_pre,
  output logic              sram_readen,
  output logic              sram_writeen,
  output logic [NUM_WL-1:0] sram_wl,
  output logic [DATA_W-1:0] sram_datain,
  output logic [DATA_W-1:0] sram_trunk,
  output logic              sram_byte_mode_enb,
  output logic              sram_tail_in,
  input  logic [DATA_W-1:0] sram_dataout
);

  localparam int unsigned MaxCycles = (PRE_CYCLES > ACCESS_CYCLES) ? PRE_CYCLES : ACCESS_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] PreLoad = CntW'(PRE_CYCLES - 1);
  localparam logic [CntW-1:0] AccLoad = CntW'(ACCESS_CYCLES - 1);

  state_e            state_d, state_q;
  logic [CntW-1:0]   cnt_d, cnt_q;
  req_t              req_d, req_q;
  logic              bm_enb_d, bm_enb_q;
  logic              ready_d, ready_q;
  logic              pre_d, pre_q;
  logic              readen_d, readen_q;
  logic              writeen_d, writeen_q;
  logic              rsp_valid_d, rsp_valid_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              wl_en;
  logic              accept;
  logic              last_phase;
  logic              capture;

  assign accept     = req_valid & ready_q;
  assign last_phase = (cnt_q == '0);

  // State and phase counter registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the counter reloads on entry and counts down to zero without wrapping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StPrech;
          cnt_d   = PreLoad;
        end
      end
      StPrech: begin
        if (last_phase) begin
          state_d = StAccess;
          cnt_d   = AccLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StAccess: begin
        if (last_phase) begin
          state_d = StRecov;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRecov: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next values, decoded from the next state so the flops line up with the state
  always_comb begin
    ready_d     = (state_d == StIdle);
    pre_d       = (state_d == StPrech);
    wl_en       = (state_d == StAccess);
    readen_d    = wl_en & ~req_q.we;
    writeen_d   = wl_en & req_q.we;
    rsp_valid_d = (state_d == StRecov);
    // Read data is taken at the edge that closes the last access cycle
    capture     = (state_q == StAccess) & last_phase & ~req_q.we;
    rdata_d     = capture ? mask_rdata(sram_dataout, req_q.byte_mode) : rdata_q;
  end

  // Request latch; busy-time request inputs never reach it
  always_comb begin
    req_d = req_q;
    if (accept) begin
      req_d.we        = req_we;
      req_d.addr      = req_addr;
      req_d.wdata     = req_wdata;
      req_d.trunc     = req_trunc;
      req_d.byte_mode = req_byte_mode;
      req_d.tail      = req_tail;
    end
    bm_enb_d = ~req_d.byte_mode;
  end

  // Datapath and strobe registers; reset drops every strobe at once
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      req_q       <= '0;
      bm_enb_q    <= 1'b1;
      ready_q     <= 1'b0;
      pre_q       <= 1'b0;
      readen_q    <= 1'b0;
      writeen_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      req_q       <= req_d;
      bm_enb_q    <= bm_enb_d;
      ready_q     <= ready_d;
      pre_q       <= pre_d;
      readen_q    <= readen_d;
      writeen_q   <= writeen_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  truncation_sram_wl_dec u_wl_dec (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_n),
    .en_i   (wl_en),
    .addr_i (req_q.addr),
    .wl_o   (sram_wl)
  );

  assign req_ready          = ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_rdata          = rdata_q;
  assign sram_pre           = pre_q;
  assign sram_readen        = readen_q;
  assign sram_writeen       = writeen_q;
  assign sram_datain        = req_q.wdata;
  assign sram_trunk         = req_q.trunc;
  assign sram_byte_mode_enb = bm_enb_q;
  assign sram_tail_in       = req_q.tail;

endmodule

// File: tb/tb_truncation_sram_ctrl.sv
// Randomised bench for truncation_sram_ctrl: two instances (2/2 and 1/3 timing) run in lockstep
// against a cycle-offset model derived from the access timeline.
module tb_truncation_sram_ctrl;

  localparam int PA = 2;
  localparam int AA = 2;
  localparam int PB = 1;
  localparam int AB = 3;
  localparam int LastK = PA + AA + 1;  // both instances share the same total length
  localparam int CapK  = PA + AA;      // last access cycle, read data must be present here

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] trunc;
    logic        bm;
    logic        tail;
    logic [31:0] rd;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_trunc = '0;
  logic        req_byte_mode = 1'b0;
  logic        req_tail = 1'b0;
  logic [31:0] dout = '0;

  logic        ready_a, rsp_a, pre_a, rden_a, wren_a, bmenb_a, tail_a;
  logic [31:0] rdata_a, datain_a, trunk_a;
  logic [1023:0] wl_a;
  logic        ready_b, rsp_b, pre_b, rden_b, wren_b, bmenb_b, tail_b;
  logic [31:0] rdata_b, datain_b, trunk_b;
  logic [1023:0] wl_b;

  int n_checks = 0;
  int n_errors = 0;

  // Values the pins are expected to hold between operations
  logic [31:0] m_datain, m_trunk, m_rdata;
  logic        m_bmenb, m_tail;

  always #5 clk = ~clk;

  truncation_sram_ctrl #(.PRE_CYCLES(PA), .ACCESS_CYCLES(AA)) u_dut_a (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_trunc(req_trunc),
    .req_byte_mode(req_byte_mode), .req_tail(req_tail), .rsp_valid(rsp_a), .rsp_rdata(rdata_a),
    .sram_pre(pre_a), .sram_readen(rden_a), .sram_writeen(wren_a), .sram_wl(wl_a),
    .sram_datain(datain_a), .sram_trunk(trunk_a), .sram_byte_mode_enb(bmenb_a),
    .sram_tail_in(tail_a), .sram_dataout(dout)
  );

  truncation_sram_ctrl #(.PRE_CYCLES(PB), .ACCESS_CYCLES(AB)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_trunc(req_trunc),
    .req_byte_mode(req_byte_mode), .req_tail(req_tail), .rsp_valid(rsp_b), .rsp_rdata(rdata_b),
    .sram_pre(pre_b), .sram_readen(rden_b), .sram_writeen(wren_b), .sram_wl(wl_b),
    .sram_datain(datain_b), .sram_trunk(trunk_b), .sram_byte_mode_enb(bmenb_b),
    .sram_tail_in(tail_b), .sram_dataout(dout)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input op_t op);
    return op.bm ? {24'h0, op.rd[7:0]} : op.rd;
  endfunction

  // k = cycles since accept (0 = not inside an operation)
  task automatic check_dut(input string nm, input int p, input int a, input int k,
                           input logic exp_ready, input op_t op,
                           input logic ready, input logic pre, input logic rden,
                           input logic wren, input logic [1023:0] wl, input logic rsp,
                           input logic [31:0] rdata, input logic [31:0] datain,
                           input logic [31:0] trunk, input logic bmenb, input logic tail);
    logic in_op, win;
    int   pc, idx;
    in_op = (k >= 1);
    win   = (k >= p + 1) && (k <= p + a);
    pc    = $countones(wl);
    idx   = -1;
    for (int i = 0; i < 1024; i++) begin
      if (wl[i] && idx < 0) idx = i;
    end
    check_eq({nm, ".ready"}, ready, exp_ready);
    check_eq({nm, ".pre"}, pre, (k >= 1) && (k <= p));
    check_eq({nm, ".readen"}, rden, win && !op.we);
    check_eq({nm, ".writeen"}, wren, win && op.we);
    check_eq({nm, ".excl"}, (32'(pre) + 32'(rden) + 32'(wren)) <= 1, 1);
    check_eq({nm, ".wl_cnt"}, pc, win ? 1 : 0);
    if (win) check_eq({nm, ".wl_idx"}, idx, op.addr);
    check_eq({nm, ".rsp_valid"}, rsp, k == p + a + 1);
    check_eq({nm, ".rdata"}, rdata, (k == p + a + 1 && !op.we) ? exp_read(op) : m_rdata);
    check_eq({nm, ".datain"}, datain, in_op ? op.wdata : m_datain);
    check_eq({nm, ".trunk"}, trunk, in_op ? op.trunc : m_trunk);
    check_eq({nm, ".bm_enb"}, bmenb, in_op ? !op.bm : m_bmenb);
    check_eq({nm, ".tail"}, tail, in_op ? op.tail : m_tail);
  endtask

  task automatic sample_both(input int k, input logic exp_ready, input op_t op);
    check_dut("a", PA, AA, k, exp_ready, op, ready_a, pre_a, rden_a, wren_a, wl_a, rsp_a,
              rdata_a, datain_a, trunk_a, bmenb_a, tail_a);
    check_dut("b", PB, AB, k, exp_ready, op, ready_b, pre_b, rden_b, wren_b, wl_b, rsp_b,
              rdata_b, datain_b, trunk_b, bmenb_b, tail_b);
  endtask

  task automatic model_reset();
    m_datain = '0;
    m_trunk  = '0;
    m_rdata  = '0;
    m_bmenb  = 1'b1;
    m_tail   = 1'b0;
  endtask

  task automatic drive_noise();
    req_valid     = 1'($urandom);
    req_we        = 1'($urandom);
    req_addr      = 10'($urandom);
    req_wdata     = $urandom;
    req_trunc     = $urandom;
    req_byte_mode = 1'($urandom);
    req_tail      = 1'($urandom);
  endtask

  // One request; abort_k > 0 pulls reset in that cycle and drops the operation
  task automatic do_op(input op_t op, input int abort_k);
    @(negedge clk);
    sample_both(0, 1'b1, op);
    req_valid     = 1'b1;
    req_we        = op.we;
    req_addr      = op.addr;
    req_wdata     = op.wdata;
    req_trunc     = op.trunc;
    req_byte_mode = op.bm;
    req_tail      = op.tail;
    dout          = $urandom;
    @(posedge clk);
    for (int k = 1; k <= LastK; k++) begin
      @(negedge clk);
      sample_both(k, 1'b0, op);
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        sample_both(0, 1'b0, op);
        return;
      end
      drive_noise();
      dout = (k == CapK) ? op.rd : $urandom;
    end
    m_datain = op.wdata;
    m_trunk  = op.trunc;
    m_bmenb  = !op.bm;
    m_tail   = op.tail;
    if (!op.we) m_rdata = exp_read(op);
  endtask

  task automatic idle_cycle(input op_t op);
    @(negedge clk);
    sample_both(0, 1'b1, op);
    drive_noise();
    req_valid = 1'b0;
  endtask

  function automatic op_t rand_op();
    op_t op;
    op.we    = 1'($urandom);
    op.addr  = 10'($urandom_range(0, 1023));
    op.wdata = $urandom;
    op.trunc = $urandom;
    op.bm    = 1'($urandom);
    op.tail  = 1'($urandom);
    op.rd    = $urandom;
    return op;
  endfunction

  initial begin
    op_t op;
    model_reset();
    op = '{we: 1'b1, addr: 10'h3FF, wdata: 32'hDEADBEEF, trunc: 32'h0, bm: 1'b0, tail: 1'b0,
           rd: 32'h0};

    // Reset state
    repeat (2) begin
      @(negedge clk);
      sample_both(0, 1'b0, op);
    end
    rst_n = 1'b1;

    // Directed: full-range write, plain read, byte-mode read
    do_op(op, 0);
    op = '{we: 1'b0, addr: 10'h000, wdata: 32'h1111_2222, trunc: 32'hFFFF_0000, bm: 1'b0,
           tail: 1'b1, rd: 32'hA5A5_1234};
    do_op(op, 0);
    op.bm   = 1'b1;
    op.addr = 10'h155;
    do_op(op, 0);

    // Reset in cycle 3 of a write, then a fresh read
    op = '{we: 1'b1, addr: 10'h2A7, wdata: 32'hCAFE_F00D, trunc: 32'h0F0F_0F0F, bm: 1'b1,
           tail: 1'b1, rd: 32'h0};
    do_op(op, 3);
    repeat (2) begin
      @(negedge clk);
      sample_both(0, 1'b0, op);
    end
    rst_n = 1'b1;
    op = '{we: 1'b0, addr: 10'h2A7, wdata: 32'h0, trunc: 32'h0, bm: 1'b0, tail: 1'b0,
           rd: 32'h5EED_BEEF};
    do_op(op, 0);

    // Random mix, mostly back-to-back with occasional idle gaps
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle(op);
      op = rand_op();
      do_op(op, 0);
    end
    idle_cycle(op);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/truncation_sram_ctrl.md
Name: truncation_sram_ctrl

Overview:
Digital access sequencer that drives the truncation SRAM macro. It accepts one read or write request at a time from the user-area logic over a valid/ready handshake. For each request it generates the precharge, one-hot wordline, enable, data, truncation and byte-mode signals in a fixed timed sequence. It captures the macro's read data and returns a one-cycle response; the macro sits directly behind this block with no other driver on its pins.

Parameters:
ADDR_W, 10, wordline address width; NUM_WL = 2**ADDR_W = 1024
DATA_W, 32, data/truncation width
PRE_CYCLES, 2, cycles PRE is held high before wordline assertion; legal range >= 1
ACCESS_CYCLES, 2, cycles the wordline plus readen/writeen are held high; legal range >= 1

Ports:
wb_clk_i  in  1  clock, all state on rising edge
wb_rst_n  in  1  reset, asynchronous assert, active-low; release is externally synchronised
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  wordline index
req_wdata  in  DATA_W  write data
req_trunc  in  DATA_W  per-bit truncation control
req_byte_mode  in  1  1 = byte mode
req_tail  in  1  tail control bit
rsp_valid  out  1  one-cycle completion pulse, reads and writes
rsp_rdata  out  DATA_W  captured read data
sram_pre  out  1  precharge, active-high
sram_readen  out  1  read enable
sram_writeen  out  1  write enable
sram_wl  out  NUM_WL  one-hot wordlines
sram_datain  out  DATA_W  to DataIn0..31
sram_trunk  out  DATA_W  to Trunk0..31
sram_byte_mode_enb  out  1  to Byte_Mode_EnableBar, = ~byte_mode
sram_tail_in  out  1  to Tail_In
sram_dataout  in  DATA_W  from DataOut0..31

Behaviour:
- Reset values: all outputs 0 except req_ready=0 while wb_rst_n low and 1 in the first cycle after release, and sram_byte_mode_enb=1. The FSM resets to IDLE.
- Mid-operation reset: wb_rst_n low immediately drops sram_wl, sram_pre and both enables to 0. The in-flight request is discarded and no rsp_valid is produced.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid, latch we, addr, wdata, trunc, byte_mode and tail; go to PRECH.
  - PRECH: sram_pre=1 for PRE_CYCLES; go to ACCESS.
  - ACCESS: sram_wl[addr]=1 and sram_writeen=we / sram_readen=~we for ACCESS_CYCLES. On a read, sram_dataout is registered at the clock edge ending the last ACCESS cycle. Go to RECOV.
  - RECOV: all strobes 0, rsp_valid=1 for one cycle; go to IDLE.
- Latency with the accept at cycle 0:
  - PRE is high for cycles 1..P.
  - WL and the enable are high for cycles P+1..P+A.
  - rsp_valid fires at cycle P+A+1.
  - The next accept is possible at cycle P+A+2. Defaults give rsp at cycle 5 and a 6-cycle request period.
- Strobe exclusivity, all outputs driven from registers (glitch-free):
  - sram_pre, sram_readen and sram_writeen are never high in the same cycle.
  - PRE and WL never overlap.
  - At most one sram_wl bit is high at any time, and only in ACCESS.
- sram_datain, sram_trunk, sram_byte_mode_enb and sram_tail_in hold the latched request values from PRECH through RECOV, then hold them until the next accept.
- rsp_rdata:
  - Read: captured data, with bits DATA_W-1:8 forced 0 when byte_mode=1.
  - Write: unchanged from the prior value.
  - Held until the next read completes.
- The request is sampled only when req_valid & req_ready. Request inputs are ignored while busy.
- The phase counter is $clog2(max(PRE_CYCLES,ACCESS_CYCLES)+1) bits wide, reloads on each state entry and never wraps.

Decomposition:
- Package truncation_sram_pkg holds:
  - the ADDR_W/DATA_W/NUM_WL constants;
  - the state enum {IDLE, PRECH, ACCESS, RECOV};
  - the request struct {we, addr, wdata, trunc, byte_mode, tail}.
- One sub-module, truncation_sram_wl_dec: registered ADDR_W-to-NUM_WL one-hot decoder with enable, output zero when the enable is low.

Test Plan:
- Write addr=0x3FF, wdata=0xDEADBEEF, trunc=0 → PRE high cycles 1–2; sram_wl[1023] and writeen high cycles 3–4; sram_datain=0xDEADBEEF; rsp_valid at cycle 5; req_ready back at cycle 6.
- Read addr=0 with sram_dataout model returning 0xA5A5_1234, byte_mode=0 → readen and wl[0] high cycles 3–4; rsp_rdata=0xA5A51234 at cycle 5.
- Read with byte_mode=1 → sram_byte_mode_enb=0 during the op; rsp_rdata=0x00000034.
- Back-to-back requests with req_valid held high → second accept at cycle 6; req_ready=0 on cycles 1–5; the assertion checks onehot0(sram_wl) and no overlap of pre/readen/writeen across 1000 random ops.
- Assert wb_rst_n=0 during cycle 3 of a write → sram_wl, writeen and pre are 0 immediately; no rsp_valid; after release, req_ready=1 and a fresh read completes normally.
- PRE_CYCLES=1, ACCESS_CYCLES=3 → rsp_valid at cycle 5 and wordline high for exactly 3 cycles.
